// File: rtl/teclado_matricial_scan.sv
// 4x4 active-low keypad scanner: column strobing, row synchronisation, press/release debounce.
// Emits one key code and a single-cycle strobe per accepted press; no auto-repeat.
module teclado_matricial_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  output logic [4:0] digito,
  output logic       cambio_digito,
  output logic       tecla_presionada
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [4:0]       CodeNone = 5'd16;

  typedef enum logic [1:0] {StScan, StDebPress, StHeld, StDebRelease} state_e;

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [3:0]       pat_q, pat_d;
  logic [4:0]       code_q, code_d;
  logic [4:0]       digito_q, digito_d;
  logic             strobe_q, strobe_d;
  logic             tecla_q, tecla_d;
  logic [3:0]       fila_m_q, fila_s_q;

  logic [1:0] row_idx;
  logic       any_low;

  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [4:0] code;
    code = CodeNone;
    case ({row, col})
      4'd0:  code = 5'd1;
      4'd1:  code = 5'd2;
      4'd2:  code = 5'd3;
      4'd3:  code = 5'd10;
      4'd4:  code = 5'd4;
      4'd5:  code = 5'd5;
      4'd6:  code = 5'd6;
      4'd7:  code = 5'd11;
      4'd8:  code = 5'd7;
      4'd9:  code = 5'd8;
      4'd10: code = 5'd9;
      4'd11: code = 5'd12;
      4'd12: code = 5'd14;
      4'd13: code = 5'd0;
      4'd14: code = 5'd15;
      4'd15: code = 5'd13;
      default: code = CodeNone;
    endcase
    return code;
  endfunction

  // Lowest-numbered low row wins when several rows are pulled down together.
  always_comb begin
    row_idx = 2'd0;
    any_low = ~&fila_s_q;
    if (!fila_s_q[0])      row_idx = 2'd0;
    else if (!fila_s_q[1]) row_idx = 2'd1;
    else if (!fila_s_q[2]) row_idx = 2'd2;
    else if (!fila_s_q[3]) row_idx = 2'd3;
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    code_d   = code_q;
    digito_d = digito_q;
    strobe_d = 1'b0;
    tecla_d  = tecla_q;
    unique case (state_q)
      StScan: begin
        if (slot_q == SlotLast) begin
          slot_d = '0;
          if (any_low) begin
            pat_d   = fila_s_q;
            code_d  = key_code(row_idx, col_q);
            cnt_d   = '0;
            state_d = StDebPress;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          slot_d = slot_q + SlotW'(1);
        end
      end
      StDebPress: begin
        if (fila_s_q != pat_q) begin
          state_d = StScan;
          col_d   = col_q + 2'd1;
          slot_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          digito_d = code_q;
          strobe_d = 1'b1;
          tecla_d  = 1'b1;
          cnt_d    = '0;
          state_d  = StHeld;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHeld: begin
        if (fila_s_q == 4'hF) begin
          cnt_d   = '0;
          state_d = StDebRelease;
        end
      end
      StDebRelease: begin
        if (fila_s_q != 4'hF) begin
          cnt_d   = '0;
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          tecla_d = 1'b0;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          slot_d  = '0;
          state_d = StScan;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StScan;
      col_q    <= 2'd0;
      slot_q   <= '0;
      cnt_q    <= '0;
      pat_q    <= 4'hF;
      code_q   <= CodeNone;
      digito_q <= CodeNone;
      strobe_q <= 1'b0;
      tecla_q  <= 1'b0;
      fila_m_q <= 4'hF;
      fila_s_q <= 4'hF;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      code_q   <= code_d;
      digito_q <= digito_d;
      strobe_q <= strobe_d;
      tecla_q  <= tecla_d;
      fila_m_q <= fila;
      fila_s_q <= fila_m_q;
    end
  end

  assign columna          = ~(4'b0001 << col_q);
  assign digito           = digito_q;
  assign cambio_digito    = strobe_q;
  assign tecla_presionada = tecla_q;

endmodule
